burst_mem_responder: RTL and testbench

//  Synthesizable responder (memory side) of the 64-bit x4 burst memory interface that mp4 drives
//  (mem_read/mem_write/mem_address/mem_wdata/mem_rdata/mem_resp). Holds a backing store of
//  256-bit lines and serves line reads/writes as 4 ascending 64-bit beats after a fixed latency.

---
 rtl/burst_mem_pkg.sv | 19 +
 rtl/burst_mem_array.sv | 25 ++
 rtl/burst_mem_responder.sv | 142 ++++++++++++++
 tb/tb_burst_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_pkg;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned LINE_W = BEATS * BEAT_W;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  typedef logic [1:0] beat_idx_t;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Line store for burst_mem_responder: one async beat read port, one sync beat write port.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int unsigned LINE_IDX_W = 8
) (
  input  logic                  clk,
  input  logic [LINE_IDX_W-1:0] rd_idx,
  input  beat_idx_t             rd_beat,
  output logic [BEAT_W-1:0]     rd_data,
  input  logic [LINE_IDX_W-1:0] wr_idx,
  input  beat_idx_t             wr_beat,
  input  logic [BEAT_W-1:0]     wr_data,
  input  logic                  we
);

  logic [BEAT_W-1:0] store [(2**LINE_IDX_W)*BEATS];

  assign rd_data = store[{rd_idx, rd_beat}];

  always_ff @(posedge clk) begin
    if (we) store[{wr_idx, wr_beat}] <= wr_data;
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 64-bit x4 burst interface, fixed latency per line burst.
// Optional BURST_MEM_JITTER_EN adds LFSR-driven 0..3 extra wait cycles per request.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned LINE_IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  localparam logic [8:0] LAT_M1 = 9'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [8:0]              lat_q, lat_d;
  beat_idx_t               beat_q, beat_d;
  logic                    op_wr_q, op_wr_d;
  logic [LINE_IDX_W-1:0]   idx_q, idx_d;
  logic [BEAT_W-1:0]       rdata_q, rdata_d;
  logic                    perr_q, perr_d;

  logic                    req;
  logic                    accept;
  logic [LINE_IDX_W-1:0]   addr_idx;
  logic [8:0]              extra_lat;
  beat_idx_t               rd_beat;
  logic [BEAT_W-1:0]       rd_data;
  logic                    we;
  logic                    unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign accept           = (state_q == IDLE) && req;
  assign addr_idx         = mem_address[LINE_IDX_W+4:5];
  assign unused_addr_bits = ^{mem_address[31:LINE_IDX_W+5], mem_address[4:0]};

`ifdef BURST_MEM_JITTER_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lfsr_q <= LFSR_SEED;
    else if (accept) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign extra_lat = {7'b0, lfsr_q[1:0]};
`else
  assign extra_lat = '0;
`endif

  // Read port runs one beat ahead so rdata_q is registered in step with mem_resp
  assign rd_beat = (state_q == BURST) ? beat_q + 2'd1 : '0;
  assign we      = (state_q == BURST) && op_wr_q && req;

  burst_mem_array #(
    .LINE_IDX_W(LINE_IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_idx  (idx_q),
    .rd_beat (rd_beat),
    .rd_data (rd_data),
    .wr_idx  (idx_q),
    .wr_beat (beat_q),
    .wr_data (mem_wdata),
    .we      (we)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    rdata_d = '0;
    perr_d  = perr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          lat_d   = LAT_M1 + extra_lat;
          op_wr_d = mem_write;
          idx_d   = addr_idx;
          if (mem_read && mem_write) perr_d = 1'b1;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (lat_q == '0) begin
          state_d = BURST;
          beat_d  = '0;
          if (!op_wr_q) rdata_d = rd_data;
        end else begin
          lat_d = lat_q - 9'd1;
        end
      end
      BURST: begin
        if (!req) begin
          state_d = IDLE;
        end else if (beat_q == 2'd3) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + 2'd1;
          if (!op_wr_q) rdata_d = rd_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_resp  = (state_q == BURST);
  assign mem_rdata = rdata_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: LATENCY=10 and LATENCY=1 instances vs a line-store model.
module tb_burst_mem_responder;

`ifdef BURST_MEM_JITTER_EN
  localparam int JIT = 3;
  localparam int N_JIT_READS = 100;
`else
  localparam int JIT = 0;
  localparam int N_JIT_READS = 12;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read    [2];
  logic        mem_write   [2];
  logic [31:0] mem_address [2];
  logic [63:0] mem_wdata   [2];
  logic [63:0] mem_rdata   [2];
  logic        mem_resp    [2];
  logic        proto_err   [2];

  int checks = 0;
  int errors = 0;

  logic [63:0] model [2][256][4];
  logic [31:0] written [2][$];

  always #5 clk = ~clk;

  burst_mem_responder #(.LATENCY(10), .LINE_IDX_W(8)) u0 (
    .clk(clk), .rst(rst), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .mem_resp(mem_resp[0]), .proto_err(proto_err[0]));

  burst_mem_responder #(.LATENCY(1), .LINE_IDX_W(8)) u1 (
    .clk(clk), .rst(rst), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .mem_resp(mem_resp[1]), .proto_err(proto_err[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 10 : 1;
  endfunction

  function automatic int line_of(input logic [31:0] addr);
    return int'(addr / 32) % 256;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One initiator-side line transaction; drop_at<4 releases the request during that beat
  task automatic burst(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] wline, input int drop_at);
    int idx;
    int n;
    int lat;
    bit got;
    idx = line_of(addr);
    @(negedge clk);
    mem_read[d]    = rd;
    mem_write[d]   = wr;
    mem_address[d] = addr;
    mem_wdata[d]   = wline[63:0];
    n   = 0;
    got = 1'b0;
    while (n < lat_of(d) + JIT + 8 && !got) begin
      @(negedge clk);
      n++;
      if (mem_resp[d]) got = 1'b1;
    end
    check("resp_arrives", 64'(got), 64'd1);
    if (!got) begin
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
      return;
    end
    lat = n - 1;
    check("latency_in_range", 64'(lat >= lat_of(d) && lat <= lat_of(d) + JIT), 64'd1);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      check("resp_beat", 64'(mem_resp[d]), 64'd1);
      if (b == drop_at) begin
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        @(negedge clk);
        check("resp_after_abort", 64'(mem_resp[d]), 64'd0);
        check("rdata_after_abort", mem_rdata[d], 64'd0);
        return;
      end
      if (wr) begin
        mem_wdata[d] = wline[64*b +: 64];
        model[d][idx][b] = wline[64*b +: 64];
      end else begin
        check("rdata_beat", mem_rdata[d], model[d][idx][b]);
      end
    end
    @(negedge clk);
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    check("resp_done_low", 64'(mem_resp[d]), 64'd0);
    check("rdata_done_zero", mem_rdata[d], 64'd0);
    if (wr) written[d].push_back(addr);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] a_line, b_line, o_line, c_line;
    logic [31:0]  addr;
    int n;
    bit got;

    for (int d = 0; d < 2; d++) begin
      mem_read[d] = 1'b0; mem_write[d] = 1'b0;
      mem_address[d] = '0; mem_wdata[d] = '0;
    end
    a_line = {64'hA3A3_0003_0000_0003, 64'hA2A2_0002_0000_0002,
              64'hA1A1_0001_0000_0001, 64'hA0A0_0000_0000_0000};
    b_line = {64'hB3B3_3333_3333_3333, 64'hB2B2_2222_2222_2222,
              64'hB1B1_1111_1111_1111, 64'hB0B0_0000_0000_0000};
    o_line = {64'h0D03_0D03_0D03_0D03, 64'h0D02_0D02_0D02_0D02,
              64'h0D01_0D01_0D01_0D01, 64'h0D00_0D00_0D00_0D00};
    c_line = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
              64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_resp", 64'(mem_resp[d]), 64'd0);
      check("reset_rdata", mem_rdata[d], 64'd0);
      check("reset_proto_err", 64'(proto_err[d]), 64'd0);
    end
    rst = 1'b1;

    // write then read line 0x40, then aliased address
    burst(0, 1'b0, 1'b1, 32'h0000_0040, a_line, 4);
    burst(0, 1'b1, 1'b0, 32'h0000_0040, '0, 4);
    burst(0, 1'b1, 1'b0, 32'h0000_2040, '0, 4);

    // LATENCY=1 instance
    burst(1, 1'b0, 1'b1, 32'h0000_0040, a_line, 4);
    burst(1, 1'b1, 1'b0, 32'h0000_0040, '0, 4);

    // aborted write keeps beats 0,1 only
    burst(0, 1'b0, 1'b1, 32'h0000_0080, o_line, 4);
    burst(0, 1'b0, 1'b1, 32'h0000_0080, b_line, 2);
    model[0][4][0] = b_line[63:0];
    model[0][4][1] = b_line[127:64];
    burst(0, 1'b1, 1'b0, 32'h0000_0080, '0, 4);

    // async reset during read beat 1
    @(negedge clk);
    mem_read[0] = 1'b1; mem_address[0] = 32'h0000_0040;
    n = 0; got = 1'b0;
    while (n < 10 + JIT + 8 && !got) begin
      @(negedge clk); n++;
      if (mem_resp[0]) got = 1'b1;
    end
    check("rst_test_resp_arrives", 64'(got), 64'd1);
    @(negedge clk);
    check("rst_test_beat1", mem_rdata[0], model[0][2][1]);
    rst = 1'b0;
    #1;
    check("rst_async_resp", 64'(mem_resp[0]), 64'd0);
    check("rst_async_rdata", mem_rdata[0], 64'd0);
    mem_read[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    burst(0, 1'b1, 1'b0, 32'h0000_0040, '0, 4);

    // read+write together: served as write, sticky proto_err
    check("proto_err_clear", 64'(proto_err[0]), 64'd0);
    burst(0, 1'b1, 1'b1, 32'h0000_00C0, c_line, 4);
    check("proto_err_set", 64'(proto_err[0]), 64'd1);
    burst(0, 1'b1, 1'b0, 32'h0000_00C0, '0, 4);
    check("proto_err_sticky", 64'(proto_err[0]), 64'd1);
    check("proto_err_other_inst", 64'(proto_err[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("proto_err_reset", 64'(proto_err[0]), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // randomized writes and aliased readbacks on both instances
    for (int i = 0; i < 24; i++) begin
      int d;
      d = i % 2;
      addr = $urandom;
      burst(d, 1'b0, 1'b1, addr, rand_line(), 4);
    end
    for (int i = 0; i < 24; i++) begin
      int d;
      int k;
      d = i % 2;
      k = $urandom_range(written[d].size() - 1, 0);
      addr = written[d][k] ^ ($urandom & 32'hFFFF_E01F);
      burst(d, 1'b1, 1'b0, addr, '0, 4);
    end

    // latency spread on repeated reads
    for (int i = 0; i < N_JIT_READS; i++) begin
      burst(0, 1'b1, 1'b0, 32'h0000_0040, '0, 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
